// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared direction, scan-state and colour definitions for sprite_motion_datapath
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_RUN  = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_t;

    localparam logic [2:0] BG_COLOR = 3'b000;

    // Sprite palette repeats every four sprites: yellow, red, cyan, magenta.
    function automatic logic [2:0] spr_color(input int idx);
        case (idx % 4)
            0:       return 3'b110;
            1:       return 3'b100;
            2:       return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

endpackage

// File: rtl/sprite_motion_datapath_if.sv
// rtl/sprite_motion_datapath_if.sv - draw request and pixel plot bundle between game FSM and datapath
interface sprite_motion_datapath_if #(
    parameter int SEL_W = 1,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
);
    logic             draw_req;
    logic [SEL_W-1:0] draw_sel;
    logic             draw_erase;
    logic             draw_busy;
    logic             draw_done;
    logic             plot_en;
    logic [X_W-1:0]   x_plot;
    logic [Y_W-1:0]   y_plot;
    logic [2:0]       plot_color;

    modport master (
        output draw_req, draw_sel, draw_erase,
        input  draw_busy, draw_done, plot_en, x_plot, y_plot, plot_color
    );

    modport slave (
        input  draw_req, draw_sel, draw_erase,
        output draw_busy, draw_done, plot_en, x_plot, y_plot, plot_color
    );
endinterface

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - free-running movement tick divider with synchronous clear and enable
module tick_timer #(
    parameter int TICK_CYCLES = 833333
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int               CNT_W = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/sprite_motion_datapath.sv
// rtl/sprite_motion_datapath.sv - N-sprite position/direction store, movement and erase/draw scanner; SPRITE_COLLIDE_EN adds sprite-0 collision flag
module sprite_motion_datapath
    import sprite_pkg::*;
#(
    parameter int N_SPRITES   = 2,
    parameter int SEL_W       = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int SPR_SIZE    = 4,
    parameter int TICK_CYCLES = 833333,
    parameter int START_X     = 8,
    parameter int START_Y     = 60
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start_game,
    input  logic                   timer_en,
    input  logic [2*N_SPRITES-1:0] dir_in,
    input  logic [N_SPRITES-1:0]   dir_we,
    output logic                   tick,
    output logic                   collide,
    sprite_motion_datapath_if.slave draw
);
    localparam int             D_W    = (SPR_SIZE > 1) ? $clog2(SPR_SIZE) : 1;
    localparam logic [D_W-1:0] D_LAST = D_W'(SPR_SIZE - 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

    logic [X_W-1:0]   pos_x [N_SPRITES];
    logic [Y_W-1:0]   pos_y [N_SPRITES];
    dir_t             dir_q [N_SPRITES];
    logic             move_pending;
    logic             move_now;

    scan_state_t      state, state_nxt;
    logic             accept;
    logic             scan_last;
    logic [SEL_W-1:0] sel_eff, sel_q;
    logic             erase_q;
    logic [X_W-1:0]   snap_x;
    logic [Y_W-1:0]   snap_y;
    logic [D_W-1:0]   dx, dy;
    logic [X_W:0]     x_sum;
    logic [Y_W:0]     y_sum;

    tick_timer #(.TICK_CYCLES(TICK_CYCLES)) u_tick_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (start_game),
        .en     (timer_en),
        .tick   (tick)
    );

    // Moves are held off while a scan runs so the snapshot and the sprite never disagree.
    assign move_now  = (tick || move_pending) && (state == SCAN_IDLE);
    assign accept    = draw.draw_req && (state == SCAN_IDLE) && !start_game;
    assign sel_eff   = (32'(draw.draw_sel) < N_SPRITES) ? draw.draw_sel : '0;
    assign scan_last = (dx == D_LAST) && (dy == D_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                dir_q[i] <= DIR_RIGHT;
            end
            move_pending <= 1'b0;
        end else if (start_game) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                pos_x[i] <= X_W'(START_X + 2 * i * SPR_SIZE);
                pos_y[i] <= Y_W'(START_Y);
                dir_q[i] <= DIR_RIGHT;
            end
            move_pending <= 1'b0;
        end else begin
            if (move_now) begin
                move_pending <= 1'b0;
                for (int i = 0; i < N_SPRITES; i++) begin
                    case (dir_q[i])
                        DIR_UP:    pos_y[i] <= (pos_y[i] == '0)    ? Y_LAST : pos_y[i] - Y_W'(1);
                        DIR_DOWN:  pos_y[i] <= (pos_y[i] == Y_LAST) ? '0     : pos_y[i] + Y_W'(1);
                        DIR_LEFT:  pos_x[i] <= (pos_x[i] == '0)    ? X_LAST : pos_x[i] - X_W'(1);
                        DIR_RIGHT: pos_x[i] <= (pos_x[i] == X_LAST) ? '0     : pos_x[i] + X_W'(1);
                    endcase
                end
            end else if (tick) begin
                move_pending <= 1'b1;
            end
            // Written after the move reads dir_q, so a same-edge write affects the next move only.
            for (int i = 0; i < N_SPRITES; i++) begin
                if (dir_we[i]) begin
                    dir_q[i] <= dir_t'(dir_in[2*i +: 2]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SCAN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_game) begin
            state_nxt = SCAN_IDLE;
        end else begin
            case (state)
                SCAN_IDLE: if (draw.draw_req) state_nxt = SCAN_RUN;
                SCAN_RUN:  if (scan_last) state_nxt = SCAN_DONE;
                SCAN_DONE: state_nxt = SCAN_IDLE;
                default:   state_nxt = SCAN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q   <= '0;
            erase_q <= 1'b0;
            snap_x  <= '0;
            snap_y  <= '0;
            dx      <= '0;
            dy      <= '0;
        end else if (accept) begin
            sel_q   <= sel_eff;
            erase_q <= draw.draw_erase;
            snap_x  <= pos_x[sel_eff];
            snap_y  <= pos_y[sel_eff];
            dx      <= '0;
            dy      <= '0;
        end else if (state == SCAN_RUN) begin
            if (dx == D_LAST) begin
                dx <= '0;
                dy <= dy + D_W'(1);
            end else begin
                dx <= dx + D_W'(1);
            end
        end
    end

    // Pixel coordinates wrap at the screen edge; outputs are forced to 0 outside SCAN.
    always_comb begin
        x_sum = {1'b0, snap_x} + (X_W+1)'(dx);
        if (x_sum > (X_W+1)'(X_MAX)) begin
            x_sum = x_sum - (X_W+1)'(X_MAX + 1);
        end
        y_sum = {1'b0, snap_y} + (Y_W+1)'(dy);
        if (y_sum > (Y_W+1)'(Y_MAX)) begin
            y_sum = y_sum - (Y_W+1)'(Y_MAX + 1);
        end
        draw.plot_en    = (state == SCAN_RUN);
        draw.draw_busy  = (state == SCAN_RUN);
        draw.draw_done  = (state == SCAN_DONE);
        draw.x_plot     = '0;
        draw.y_plot     = '0;
        draw.plot_color = '0;
        if (state == SCAN_RUN) begin
            draw.x_plot     = x_sum[X_W-1:0];
            draw.y_plot     = y_sum[Y_W-1:0];
            draw.plot_color = erase_q ? BG_COLOR : spr_color(int'(sel_q));
        end
    end

`ifdef SPRITE_COLLIDE_EN
    logic           overlap;
    logic [X_W-1:0] adx;
    logic [Y_W-1:0] ady;

    always_comb begin
        overlap = 1'b0;
        adx     = '0;
        ady     = '0;
        for (int i = 1; i < N_SPRITES; i++) begin
            adx = (pos_x[0] > pos_x[i]) ? pos_x[0] - pos_x[i] : pos_x[i] - pos_x[0];
            ady = (pos_y[0] > pos_y[i]) ? pos_y[0] - pos_y[i] : pos_y[i] - pos_y[0];
            if ((adx < X_W'(SPR_SIZE)) && (ady < Y_W'(SPR_SIZE))) begin
                overlap = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            collide <= 1'b0;
        end else begin
            collide <= overlap;
        end
    end
`else
    assign collide = 1'b0;
`endif

endmodule

// File: doc/sprite_motion_datapath.md
# sprite_motion_datapath

Parametrised multi-sprite datapath for the Pacman game. It holds position and direction for N sprites and advances every sprite one pixel per movement tick, wrapping at the screen edges. It also runs an erase/draw scan sequencer that streams SPR_SIZE×SPR_SIZE pixel coordinates and colour to the VGA adapter. It sits between the game control FSM and the VGA adapter, and replaces the single-sprite datapath.

## Interface
- N_SPRITES, 2: sprite count (1..8); SEL_W = max(1, clog2(N_SPRITES))
- X_W, 8: x coordinate width
- Y_W, 7: y coordinate width
- X_MAX, 159: last visible column
- Y_MAX, 119: last visible row
- SPR_SIZE, 4: sprite edge in pixels (power of two, ≤16)
- TICK_CYCLES, 833333: clocks per movement tick (≥2)
- START_X, 8 / START_Y, 60: sprite 0 start position

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start_game  in  1  load start state for all sprites
- timer_en  in  1  tick counter runs while high
- dir_in  in  2*N_SPRITES  requested direction, sprite i at bits [2i+1:2i]
- dir_we  in  N_SPRITES  per-sprite direction write strobe
- draw_req  in  1  start a scan (accepted only when idle)
- draw_sel  in  SEL_W  sprite to scan
- draw_erase  in  1  1 = background colour, 0 = sprite colour
- tick  out  1  one-cycle movement pulse (timer_done)
- draw_busy  out  1  scan in progress
- draw_done  out  1  one-cycle pulse after last pixel
- plot_en  out  1  x_plot/y_plot/plot_color valid
- x_plot  out  X_W
- y_plot  out  Y_W
- plot_color  out  3
- collide  out  1  sprite 0 overlaps another sprite (see Configuration)

## Operation
- Reset: positions 0, directions RIGHT, counter 0, move_pending 0, FSM IDLE, all outputs 0.
- start_game (synchronous, highest priority):
  - sprite i ← (START_X + 2·i·SPR_SIZE, START_Y), direction RIGHT.
  - Counter and move_pending cleared.
  - FSM forced to IDLE with no draw_done.
- Tick counter: increments while timer_en; at TICK_CYCLES−1 it wraps to 0 and tick is high for that cycle. timer_en low freezes the count.
- Move: applied on the edge where (tick OR move_pending) and FSM is IDLE.
  - Each sprite moves ±1 on one axis per its direction: UP y−1, DOWN y+1, LEFT x−1, RIGHT x+1.
  - Wrap: x = X_MAX going right → 0; x = 0 going left → X_MAX. Same on y with Y_MAX.
- Tick while FSM not IDLE: move_pending set, move applied on the first IDLE cycle, pending cleared. It is a one-deep flag; further ticks while pending are dropped.
- dir_we: the direction register is written on the clock edge. If a move is applied on the same edge, the move uses the old direction.
- Scan FSM: IDLE → SCAN → DONE → IDLE.
  - IDLE: draw_req latches draw_sel, draw_erase and the selected sprite's position (snapshot, so no tearing).
  - SCAN: dx inner loop, dy outer loop, SPR_SIZE² cycles. Output x = (snap_x + dx) wrapped mod X_MAX+1; y likewise.
  - DONE: draw_done high for one cycle.
- plot_color: 0 when erasing, otherwise SPR_COLOR[sel].
- draw_sel ≥ N_SPRITES: treated as sprite 0.

## Timing
- draw_req accepted in IDLE → plot_en, draw_busy high the next cycle. First pixel is (snap_x, snap_y).
- Last pixel at request + SPR_SIZE² cycles; draw_done at request + SPR_SIZE² + 1; draw_busy low in DONE.
- draw_req in DONE or SCAN is ignored; earliest re-accept is the cycle after DONE.
- Positions are visible to a snapshot one cycle after the move edge.
- resetn assertion mid-scan: all outputs 0 immediately (asynchronous).

## Configuration
- SPRITE_COLLIDE_EN defined:
  - collide is registered and updates every cycle.
  - It is high when the SPR_SIZE box of sprite 0 overlaps the box of any sprite i>0 (|dx|<SPR_SIZE and |dy|<SPR_SIZE, no wrap-around consideration). Latency 1 cycle after a position change.
- Not defined: collide tied 0 and no comparator logic is synthesised.

## Structure
- sprite_pkg:
  - dir_t encoding UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - BG_COLOR=3'b000; SPR_COLOR table (0: 3'b110 yellow, 1: 3'b100 red, 2: 3'b011 cyan, 3: 3'b101 magenta, repeated).
  - Scan state encoding.
- Sub-module tick_timer (parameter TICK_CYCLES; ports clk, resetn, clear, en, tick).

## Test plan
- Reset then start_game with N_SPRITES=2 → sprite0 (8,60), sprite1 (16,60), both RIGHT; tick after exactly TICK_CYCLES (use 4) enabled cycles → sprites at (9,60), (17,60).
- Sprite 0 at x=159 moving RIGHT, tick → x=0. Sprite at y=0 moving UP, tick → y=119.
- draw_req sel=1 erase=0 at (17,60) → 16 plot_en cycles (17..20, 60..63), colour 3'b100; draw_done 17 cycles after the request.
- Tick during SCAN → positions unchanged until the cycle after DONE, then +1. Two ticks during one long scan → only one move.
- dir_we UP on the same edge as a move → move uses RIGHT; the next tick moves y−1.
- SPRITE_COLLIDE_EN: sprite 0 at (10,60), sprite 1 at (13,60) → collide=1; at (14,60) → collide=0; undefined → collide always 0.
